// File: rtl/game_pkg.sv
// Constants and state encoding shared by the rival spawner, display stage and controller.
package game_pkg;

  localparam int CAR_W      = 14;
  localparam int CAR_H      = 16;
  localparam int ROAD_X_MIN = 244;
  localparam int ROAD_X_MAX = 318;
  localparam int ROAD_Y_TOP = 150;
  localparam int ROAD_Y_BOT = 390;
  localparam int LANE_PITCH = 26;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    ACTIVE = 2'd1,
    HIT    = 2'd2
  } rival_state_t;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advancing once per enabled cycle.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] state
);

  // Shift left, feeding back the XOR of the tap bits into bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (en) begin
      state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
    end
  end

endmodule

// File: rtl/rival_car_spawner.sv
// Spawns one rival car in a random lane, scrolls it down the road each frame,
// scores dodged cars and latches a collision with the player car.
module rival_car_spawner #(
  parameter int         PIX_W         = 10,
  parameter int         ROAD_X_MIN    = game_pkg::ROAD_X_MIN,
  parameter int         ROAD_Y_TOP    = game_pkg::ROAD_Y_TOP,
  parameter int         ROAD_Y_BOT    = game_pkg::ROAD_Y_BOT,
  parameter int         CAR_W         = game_pkg::CAR_W,
  parameter int         CAR_H         = game_pkg::CAR_H,
  parameter int         LANE_PITCH    = game_pkg::LANE_PITCH,
  parameter int         RIVAL_SPEED   = 2,
  parameter int         SPAWN_GAP_MIN = 8,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             pause,
  input  logic             restart,
  input  logic [PIX_W-1:0] main_x,
  input  logic [PIX_W-1:0] main_y,
  output logic [PIX_W-1:0] rival_x,
  output logic [PIX_W-1:0] rival_y,
  output logic             rival_valid,
  output logic             collide,
  output logic [7:0]       score
);

  import game_pkg::*;

  localparam int GAP_W = $clog2(SPAWN_GAP_MIN + 15);
  localparam int EW    = PIX_W + 1;

  rival_state_t     state;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       lfsr;
  logic             tick;
  logic [1:0]       lane;
  logic [PIX_W-1:0] lane_x;
  logic [GAP_W-1:0] gap_rand;
  logic [EW-1:0]    next_y;
  logic             overlap;
  logic             off_road;

  assign tick = frame_tick & ~pause;

  // Restart consumes a coincident tick, and the rival frozen in HIT must not reshuffle the sequence.
  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick & ~restart & (state != HIT)),
    .state (lfsr)
  );

  // Lane/gap selection from the current LFSR value and the next-row overlap/exit tests.
  always_comb begin
    lane     = (lfsr[1:0] == 2'd3) ? 2'd1 : lfsr[1:0];
    lane_x   = PIX_W'(ROAD_X_MIN + 4) + PIX_W'(lane) * PIX_W'(LANE_PITCH);
    gap_rand = GAP_W'(SPAWN_GAP_MIN - 1) + GAP_W'(lfsr[5:2]);
    next_y   = {1'b0, rival_y} + EW'(RIVAL_SPEED);
    overlap  = (next_y < ({1'b0, main_y} + EW'(CAR_H))) &&
               ((next_y + EW'(CAR_H)) > {1'b0, main_y}) &&
               ({1'b0, rival_x} < ({1'b0, main_x} + EW'(CAR_W))) &&
               (({1'b0, rival_x} + EW'(CAR_W)) > {1'b0, main_x});
    off_road = (next_y + EW'(CAR_H)) > EW'(ROAD_Y_BOT);
  end

  // Spawn/move/hit state machine; restart re-arms everything except the LFSR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT;
      gap_cnt     <= GAP_W'(SPAWN_GAP_MIN - 1);
      rival_x     <= PIX_W'(ROAD_X_MIN + 4);
      rival_y     <= PIX_W'(ROAD_Y_TOP);
      rival_valid <= 1'b0;
      collide     <= 1'b0;
      score       <= '0;
    end else if (restart) begin
      state       <= WAIT;
      gap_cnt     <= GAP_W'(SPAWN_GAP_MIN - 1);
      rival_x     <= PIX_W'(ROAD_X_MIN + 4);
      rival_y     <= PIX_W'(ROAD_Y_TOP);
      rival_valid <= 1'b0;
      collide     <= 1'b0;
      score       <= '0;
    end else if (tick) begin
      case (state)
        WAIT: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else begin
            rival_x     <= lane_x;
            rival_y     <= PIX_W'(ROAD_Y_TOP);
            rival_valid <= 1'b1;
            state       <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (overlap) begin
            rival_y <= next_y[PIX_W-1:0];
            collide <= 1'b1;
            state   <= HIT;
          end else if (off_road) begin
            rival_valid <= 1'b0;
            if (score != '1) score <= score + 1'b1;
            gap_cnt <= gap_rand;
            state   <= WAIT;
          end else begin
            rival_y <= next_y[PIX_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
